gen_fifo: RTL
=============

# gen_fifo

Parametrised synchronous FIFO that succeeds the single-register `gen` block. The legacy block only captured `din` on `wrb` and presented it on `rdout`. This block buffers up to `DEPTH` words of `WIDTH` bits behind the same active-low write strobe, and adds an active-low read strobe, occupancy count and full/empty status. It sits between MyHDL-driven stimulus/producer logic and a consumer in the same `sysclk` domain.

## Interface
- `WIDTH`, 16, data word width in bits (≥1)
- `DEPTH`, 16, number of entries; power of two, ≥2
- `ADDR_W`, `$clog2(DEPTH)`, derived pointer width; not overridden
- `sysclk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `wrb`  in  1  active-low write strobe; one word per cycle held low
- `din`  in  WIDTH  write data, sampled when `wrb`=0
- `rdb`  in  1  active-low read strobe; one word per cycle held low
- `rdout`  out  WIDTH  registered read data
- `rvalid`  out  1  high for one cycle when `rdout` holds a newly popped word
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `count`  out  ADDR_W+1  current occupancy, 0..DEPTH

## Operation
- Storage: `DEPTH`×`WIDTH` array, write pointer `wp` and read pointer `rp` (`ADDR_W` bits), plus registered `count`.
- Read accepted (`rd_ok`) = `rdb`==0 && !empty. No fall-through: a read while empty is rejected even when a write is accepted in the same cycle.
- Write accepted (`wr_ok`) = `wrb`==0 && (!full || `rd_ok`). A write to a full FIFO succeeds only with a simultaneous accepted read.
- On `wr_ok`: `mem[wp]`<=`din`, `wp`<=`wp`+1.
- On `rd_ok`: `rdout`<=`mem[rp]`, `rp`<=`rp`+1, `rvalid`<=1. Otherwise `rvalid`<=0 and `rdout` holds its value.
- Count update: +1 if only `wr_ok`, −1 if only `rd_ok`, unchanged if both or neither.
- `full` and `empty` are registered and updated together with `count`. They are never combinational from the strobes.
- Pointers wrap modulo `DEPTH` via natural `ADDR_W`-bit overflow. No explicit compare is used for wrap.
- Rejected writes and reads are silently dropped. No state changes.

## Timing
- Reset (sync, `reset`=1 at a rising edge): `wp`=`rp`=0, `count`=0, `empty`=1, `full`=0, `rvalid`=0, `rdout`=0. Memory contents are not cleared.
- Reset overrides strobes in the same cycle. A reset mid-stream discards all buffered words.
- Write-to-status latency: 1 cycle. Write at edge N → `empty`=0 and `count`=1 after edge N.
- Earliest read of that word is at edge N+1. `rdout` and `rvalid` are valid after edge N+1.
- Read latency: 1 cycle from accepted strobe to `rdout`/`rvalid`.
- Sustained throughput is 1 write plus 1 read per cycle when neither full nor empty.

## Configuration
- Macro: `GEN_FIFO_ERR_EN`.
- Defined: adds outputs `ovf` and `udf` (1 bit each, reset 0, sticky until `reset`).
  - `ovf` sets on a rejected write (`wrb`=0 && full && !`rd_ok`).
  - `udf` sets on a rejected read (`rdb`=0 && empty).
- Undefined: neither port nor its logic exists. All other behaviour is identical.

## Structure
- Shared package `gen_pkg`:
  - default `GEN_WIDTH`=16 and `GEN_DEPTH`=16 constants
  - a `gen_word_t` typedef for the default data word
- Sub-module `gen_fifo_ctrl`: pointers, count, full/empty and accept logic, parametrised on `DEPTH`.
- The top level holds the storage array and the `rdout`/`rvalid` registers.

## Test plan
All scenarios use `WIDTH`=16, `DEPTH`=4.
- Reset then idle → `empty`=1, `full`=0, `count`=0, `rdout`=0x0000, `rvalid`=0.
- Write 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles → `full`=1, `count`=4. A fifth write of 0x5555 is dropped. With `GEN_FIFO_ERR_EN` defined, `ovf`=1.
- From full, read 4 times → `rdout` sequence is 0x1111, 0x2222, 0x3333, 0x4444 with `rvalid`=1 each cycle. Then `empty`=1. A fifth read leaves `rdout`=0x4444 and `rvalid`=0; with the macro defined, `udf`=1.
- Wrap: run 10 interleaved write/read pairs of values 0x0000..0x0009 → values read out in order. `count` is never above 1, and pointers wrap past 3.
- Simultaneous access:
  - When full, write 0xAAAA together with a read → the read returns the oldest word, 0xAAAA is stored, and `count` stays 4.
  - When empty, write together with a read → the read is rejected and `count`=1.
- Load 3 words, assert `reset` with `wrb`=`rdb`=0 → after the edge, `count`=0, `empty`=1, `rvalid`=0, and no word is stored.

Source files
------------

// File: rtl/gen_pkg.sv
// gen_pkg: shared defaults and word type for the gen block family
package gen_pkg;
  localparam int GEN_WIDTH = 16;
  localparam int GEN_DEPTH = 16;
  typedef logic [GEN_WIDTH-1:0] gen_word_t;
endpackage

// File: rtl/gen_fifo_ctrl.sv
// gen_fifo_ctrl: pointers, occupancy, registered full/empty and read/write accept logic
module gen_fifo_ctrl import gen_pkg::*; #(
  parameter int DEPTH = GEN_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          wrb,
  input  logic          rdb,
  output logic          wr_ok,
  output logic          rd_ok,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] wp,
  output logic [AW-1:0] rp,
  output logic [AW:0]   count
);
  logic [AW:0] nxt;
  assign rd_ok = !rdb && !empty;
  assign wr_ok = !wrb && (!full || rd_ok);
  always_comb nxt = count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
  always_ff @(posedge sysclk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      wp    <= wp + AW'(wr_ok);
      rp    <= rp + AW'(rd_ok);
      count <= nxt;
      full  <= nxt == (AW+1)'(DEPTH);
      empty <= nxt == '0;
    end
  end
endmodule

// File: rtl/gen_fifo.sv
// gen_fifo: synchronous FIFO with active-low strobes; GEN_FIFO_ERR_EN adds sticky ovf/udf flags
module gen_fifo import gen_pkg::*; #(
  parameter int WIDTH  = GEN_WIDTH,
  parameter int DEPTH  = GEN_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             wrb,
  input  logic [WIDTH-1:0] din,
  input  logic             rdb,
  output logic [WIDTH-1:0] rdout,
  output logic             rvalid,
  output logic             full,
  output logic             empty,
  output logic [ADDR_W:0]  count
`ifdef GEN_FIFO_ERR_EN
  ,
  output logic             ovf,
  output logic             udf
`endif
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wp, rp;
  logic wr_ok, rd_ok;
  gen_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .sysclk(sysclk), .reset(reset), .wrb(wrb), .rdb(rdb),
    .wr_ok(wr_ok), .rd_ok(rd_ok), .full(full), .empty(empty),
    .wp(wp), .rp(rp), .count(count)
  );
  always_ff @(posedge sysclk) if (!reset && wr_ok) mem[wp] <= din;
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rdout  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_ok;
      if (rd_ok) rdout <= mem[rp];
    end
  end
`ifdef GEN_FIFO_ERR_EN
  always_ff @(posedge sysclk) begin
    if (reset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= ovf | (!wrb && full && !rd_ok);
      udf <= udf | (!rdb && empty);
    end
  end
`endif
endmodule
